// File: rtl/photon_pulse_pkg.sv
// Shared types and constants for the photon stimulus pulse generator:
// FSM state encoding, LFSR tap mask/seed and a small sizing helper.
package photon_pulse_pkg;

    typedef enum logic [1:0] {
        ST_STARTUP = 2'd0,
        ST_HIGH    = 2'd1,
        ST_LOW     = 2'd2,
        ST_GAP     = 2'd3
    } state_t;

    // Fibonacci taps for x^16 + x^14 + x^13 + x^11 + 1 (state bits 15, 13, 12, 10)
    localparam logic [15:0] LFSR_TAP_MASK = 16'hB400;
    localparam logic [15:0] LFSR_SEED     = 16'hACE1;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/photon_pulse_lfsr16.sv
// 16-bit Fibonacci LFSR stepping every cycle; seeded on asynchronous active-low reset.
// Only instantiated when the low-phase jitter option is built in.
module lfsr16
    import photon_pulse_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] out
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAP_MASK)};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign out = lfsr_q;

endmodule

// File: rtl/photon_pulse_top.sv
// Periodic burst pulse generator driving the analog front-end stimulus input.
// Build option SIGNAL_JITTER_EN adds an LFSR-driven random extension to each low phase.
module photon_pulse_top
    import photon_pulse_pkg::*;
#(
    parameter int START_DELAY   = 16,
    parameter int PERIOD_CYCLES = 50,
    parameter int PULSE_CYCLES  = 5,
    parameter int BURST_LEN     = 4,
    parameter int GAP_CYCLES    = 200,
    parameter int JITTER_BITS   = 3
) (
    input  logic clk,
    input  logic rst,
    output logic signal
);

    localparam int CNT_W = $clog2(max3(START_DELAY, PERIOD_CYCLES, GAP_CYCLES) + 1) + 1;
    localparam int IDX_W = $clog2(BURST_LEN + 1);

    // Every phase of N cycles loads N-1; startup loads the full delay because it
    // starts counting on the first edge that sees the synchronized reset high.
    localparam logic [CNT_W-1:0] LOAD_START = CNT_W'(START_DELAY);
    localparam logic [CNT_W-1:0] LOAD_HIGH  = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOAD_LOW   = CNT_W'(PERIOD_CYCLES - PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOAD_GAP   = CNT_W'(GAP_CYCLES - 1);

    if (PULSE_CYCLES < 1) begin : g_chk_pulse
        $error("photon_pulse_top: PULSE_CYCLES must be >= 1");
    end
    if (PERIOD_CYCLES <= PULSE_CYCLES) begin : g_chk_period
        $error("photon_pulse_top: PERIOD_CYCLES must exceed PULSE_CYCLES");
    end
    if (BURST_LEN < 1) begin : g_chk_burst
        $error("photon_pulse_top: BURST_LEN must be >= 1");
    end
    if (JITTER_BITS < 1 || JITTER_BITS > 16) begin : g_chk_jitter
        $error("photon_pulse_top: JITTER_BITS must be in 1..16");
    end

    logic [1:0]       rst_sync_q;
    logic             run;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             signal_q, signal_d;
    logic [CNT_W-1:0] low_load;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign run = rst_sync_q[1];

`ifdef SIGNAL_JITTER_EN
    localparam logic [15:0] JITTER_MASK = 16'((1 << JITTER_BITS) - 1);

    logic [15:0] lfsr_w;

    lfsr16 u_lfsr (
        .clk (clk),
        .rst (rst),
        .out (lfsr_w)
    );

    assign low_load = LOAD_LOW + CNT_W'(lfsr_w & JITTER_MASK);
`else
    assign low_load = LOAD_LOW;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        if (!run) begin
            state_d = ST_STARTUP;
            cnt_d   = LOAD_START;
            idx_d   = '0;
        end else begin
            case (state_q)
                ST_STARTUP: begin
                    if (cnt_q == '0) begin
                        state_d = ST_HIGH;
                        cnt_d   = LOAD_HIGH;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (cnt_q == '0) begin
                        state_d = ST_LOW;
                        cnt_d   = low_load;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ST_LOW: begin
                    if (cnt_q == '0) begin
                        if (int'(idx_q) < BURST_LEN - 1) begin
                            state_d = ST_HIGH;
                            cnt_d   = LOAD_HIGH;
                            idx_d   = idx_q + 1'b1;
                        end else if (GAP_CYCLES == 0) begin
                            state_d = ST_HIGH;
                            cnt_d   = LOAD_HIGH;
                            idx_d   = '0;
                        end else begin
                            state_d = ST_GAP;
                            cnt_d   = LOAD_GAP;
                            idx_d   = '0;
                        end
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ST_GAP: begin
                    if (cnt_q == '0) begin
                        state_d = ST_HIGH;
                        cnt_d   = LOAD_HIGH;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_d = ST_STARTUP;
                    cnt_d   = LOAD_START;
                    idx_d   = '0;
                end
            endcase
        end
        signal_d = (state_d == ST_HIGH);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_STARTUP;
            cnt_q    <= '0;
            idx_q    <= '0;
            signal_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            signal_q <= signal_d;
        end
    end

    assign signal = signal_q;

endmodule

// File: tb/tb_photon_pulse_top.sv
// Directed self-checking bench for photon_pulse_top: default instance plus a
// GAP_CYCLES=0 / BURST_LEN=1 instance; jitter checks run when SIGNAL_JITTER_EN is defined.
module tb_photon_pulse_top;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sig_a;
    logic sig_b;
    int   tests = 0;
    int   fails = 0;

    always #10 clk = ~clk;

    photon_pulse_top dut (
        .clk    (clk),
        .rst    (rst),
        .signal (sig_a)
    );

    photon_pulse_top #(
        .GAP_CYCLES (0),
        .BURST_LEN  (1)
    ) dut_nogap (
        .clk    (clk),
        .rst    (rst),
        .signal (sig_b)
    );

    // Count falling edges until the selected output reaches lvl (bounded).
    task automatic wait_lvl(input bit which, input logic lvl, input int max_cyc,
                            output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        while (!ok && n < max_cyc) begin
            @(negedge clk);
            n++;
            if ((which ? sig_b : sig_a) === lvl) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        int bad_a = 0;
        int bad_b = 0;
        rst = 1'b1;
        #1 rst = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (sig_a !== 1'b0) bad_a++;
            if (sig_b !== 1'b0) bad_b++;
        end
        tests++;
        if (bad_a !== 0) begin
            fails++;
            $display("FAIL reset_hold_a: %0d cycles with signal != 0, expected 0", bad_a);
        end
        tests++;
        if (bad_b !== 0) begin
            fails++;
            $display("FAIL reset_hold_b: %0d cycles with signal != 0, expected 0", bad_b);
        end
    endtask

    // Release at a falling edge: 2 synchronizer edges, t0 is the 3rd rising edge,
    // first rise 16 edges later -> seen high on the 19th falling edge.
    task automatic test_startup();
        int n;
        bit ok;
        @(negedge clk);
        rst = 1'b1;
        wait_lvl(1'b0, 1'b1, 100, n, ok);
        tests++;
        if (!ok || n !== 19) begin
            fails++;
            $display("FAIL startup_first_rise: got %0d cycles (ok=%0d), expected 19", n, ok);
        end
        wait_lvl(1'b0, 1'b0, 20, n, ok);
        tests++;
        if (!ok || n !== 5) begin
            fails++;
            $display("FAIL startup_high: got %0d cycles (ok=%0d), expected 5", n, ok);
        end
        wait_lvl(1'b0, 1'b1, 100, n, ok);
        tests++;
        if (!ok || n !== 45) begin
            fails++;
            $display("FAIL startup_low: got %0d cycles (ok=%0d), expected 45", n, ok);
        end
    endtask

    // Starts at rise #2 of the first burst; walks through to rise #9.
    task automatic test_burst();
        int exp_rr[7] = '{50, 50, 250, 50, 50, 50, 250};
        int h;
        int l;
        int rr;
        int burst_sum = 0;
        bit ok_h;
        bit ok_l;
        for (int i = 0; i < 7; i++) begin
            wait_lvl(1'b0, 1'b0, 20, h, ok_h);
            wait_lvl(1'b0, 1'b1, 400, l, ok_l);
            rr = h + l;
            tests++;
            if (!ok_h || h !== 5) begin
                fails++;
                $display("FAIL burst_high[%0d]: got %0d cycles, expected 5", i, h);
            end
            tests++;
            if (!ok_l || rr !== exp_rr[i]) begin
                fails++;
                $display("FAIL burst_rise_to_rise[%0d]: got %0d cycles, expected %0d", i, rr, exp_rr[i]);
            end
            if (i >= 3) burst_sum += rr;
        end
        tests++;
        if (burst_sum !== 400) begin
            fails++;
            $display("FAIL burst_period: got %0d cycles, expected 400", burst_sum);
        end
    endtask

    task automatic test_mid_pulse_reset();
        int n;
        int bad = 0;
        bit ok;
        @(posedge clk);
        #2;
        tests++;
        if (sig_a !== 1'b1) begin
            fails++;
            $display("FAIL midreset_pre: signal=%b, expected 1", sig_a);
        end
        rst = 1'b0;
        #1;
        tests++;
        if (sig_a !== 1'b0) begin
            fails++;
            $display("FAIL midreset_async_clear: signal=%b, expected 0", sig_a);
        end
        repeat (5) begin
            @(negedge clk);
            if (sig_a !== 1'b0) bad++;
        end
        tests++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL midreset_hold: %0d cycles with signal != 0, expected 0", bad);
        end
        rst = 1'b1;
        wait_lvl(1'b0, 1'b1, 100, n, ok);
        tests++;
        if (!ok || n !== 19) begin
            fails++;
            $display("FAIL midreset_restart_rise: got %0d cycles (ok=%0d), expected 19", n, ok);
        end
        wait_lvl(1'b0, 1'b0, 20, n, ok);
        tests++;
        if (!ok || n !== 5) begin
            fails++;
            $display("FAIL midreset_restart_high: got %0d cycles (ok=%0d), expected 5", n, ok);
        end
    endtask

    task automatic test_no_gap();
        int n;
        bit ok;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        wait_lvl(1'b1, 1'b1, 100, n, ok);
        tests++;
        if (!ok || n !== 19) begin
            fails++;
            $display("FAIL nogap_first_rise: got %0d cycles (ok=%0d), expected 19", n, ok);
        end
        for (int i = 0; i < 4; i++) begin
            wait_lvl(1'b1, 1'b0, 20, n, ok);
            tests++;
            if (!ok || n !== 5) begin
                fails++;
                $display("FAIL nogap_high[%0d]: got %0d cycles, expected 5", i, n);
            end
            wait_lvl(1'b1, 1'b1, 100, n, ok);
            tests++;
            if (!ok || n !== 45) begin
                fails++;
                $display("FAIL nogap_low[%0d]: got %0d cycles, expected 45", i, n);
            end
        end
    endtask

`ifdef SIGNAL_JITTER_EN
    task automatic test_jitter();
        int hi[2][8];
        int lo[2][8];
        int n;
        bit ok;
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            rst = 1'b0;
            repeat (3) @(negedge clk);
            rst = 1'b1;
            wait_lvl(1'b1, 1'b1, 100, n, ok);
            tests++;
            if (!ok || n !== 19) begin
                fails++;
                $display("FAIL jitter_first_rise[%0d]: got %0d cycles, expected 19", r, n);
            end
            for (int i = 0; i < 8; i++) begin
                wait_lvl(1'b1, 1'b0, 20, hi[r][i], ok);
                if (!ok) hi[r][i] = -1;
                wait_lvl(1'b1, 1'b1, 100, lo[r][i], ok);
                if (!ok) lo[r][i] = -1;
            end
        end
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (hi[0][i] !== 5) begin
                fails++;
                $display("FAIL jitter_high[%0d]: got %0d cycles, expected 5", i, hi[0][i]);
            end
            tests++;
            if (lo[0][i] < 45 || lo[0][i] > 52) begin
                fails++;
                $display("FAIL jitter_low_range[%0d]: got %0d cycles, expected 45..52", i, lo[0][i]);
            end
            tests++;
            if (hi[1][i] !== hi[0][i] || lo[1][i] !== lo[0][i]) begin
                fails++;
                $display("FAIL jitter_repeat[%0d]: run2 %0d/%0d, expected %0d/%0d",
                         i, hi[1][i], lo[1][i], hi[0][i], lo[0][i]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
`ifdef SIGNAL_JITTER_EN
        test_jitter();
`else
        test_startup();
        test_burst();
        test_mid_pulse_reset();
        test_no_gap();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
